// File: rtl/bus_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : bus_responder
//  Purpose  : Responder side of an enable/ack four-phase bus. Captures a
//             single-word read or write request into a small register file,
//             waits a programmable number of cycles, then completes the
//             transfer by holding ack until the initiator drops enable.
//             Aborted requests raise a one-cycle err pulse. Completed
//             transfers are counted in a wrapping 16-bit counter.
//
//  Ports    : clk        bus clock, rising-edge active
//             rstn       asynchronous active-low reset
//             enable     initiator request, held until ack is seen
//             write      1 = write, 0 = read (sampled with enable)
//             addr       word address (sampled with enable)
//             wdata      write data (sampled with enable)
//             rdata      read data or write echo, valid while ack = 1
//             ack        transfer complete, held until enable drops
//             busy       high whenever the responder is not idle
//             err        one-cycle pulse when a request is aborted
//             txn_count  completed-transfer count, wraps at 16 bits
//
//  Revision : 1.0 - initial release
// ============================================================================
module bus_responder #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 2,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              enable,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              busy,
    output logic              err,
    output logic [15:0]       txn_count
);

    localparam int c_DEPTH = 2 ** ADDR_W;
    // A zero wait still needs a one-bit counter so the WAIT state has
    // something to compare against.
    localparam int c_CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_write_q;
    logic [ADDR_W-1:0]   r_addr_q;
    logic [DATA_W-1:0]   r_wdata_q;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;
    logic [15:0]         r_txn_count;
    logic [DATA_W-1:0]   r_mem [0:c_DEPTH-1];

    logic                w_capture;
    logic                w_cnt_dec;
    logic                w_abort;
    logic                w_complete;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control decode. ack/busy are pure decodes of the
    // registered state, so they fall the instant reset forces IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_cnt_dec    = 1'b0;
        w_abort      = 1'b0;
        w_complete   = 1'b0;
        ack          = 1'b0;
        busy         = 1'b1;

        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (enable) begin
                    w_state_next = ST_WAIT;
                    w_capture    = 1'b1;
                end
            end
            ST_WAIT: begin
                // Initiator withdrawing takes precedence over the wait
                // expiring, so a zero-wait request can still be aborted.
                if (!enable) begin
                    w_state_next = ST_IDLE;
                    w_abort      = 1'b1;
                end else if (r_cnt == '0) begin
                    w_state_next = ST_ACK;
                    w_complete   = 1'b1;
                end else begin
                    w_cnt_dec    = 1'b1;
                end
            end
            ST_ACK: begin
                ack = 1'b1;
                if (!enable) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture, wait counter, register file and reporting.
    // The memory update happens on the WAIT->ACK edge so rdata is
    // already valid in the first ack cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt       <= '0;
            r_write_q   <= 1'b0;
            r_addr_q    <= '0;
            r_wdata_q   <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_txn_count <= '0;
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_err <= w_abort;

            if (w_capture) begin
                r_write_q <= write;
                r_addr_q  <= addr;
                r_wdata_q <= wdata;
                r_cnt     <= c_CNT_LOAD;
            end else if (w_cnt_dec) begin
                r_cnt     <= r_cnt - c_CNT_W'(1);
            end

            if (w_complete) begin
                if (r_write_q) begin
                    r_mem[r_addr_q] <= r_wdata_q;
                    r_rdata         <= r_wdata_q;
                end else begin
                    r_rdata         <= r_mem[r_addr_q];
                end
                r_txn_count <= r_txn_count + 16'd1;
            end
        end
    end

    assign rdata     = r_rdata;
    assign err       = r_err;
    assign txn_count = r_txn_count;

endmodule
`default_nettype wire
